// File: rtl/bp_pht_update_ctrl.sv
// rtl/bp_pht_update_ctrl.sv - PHT init sweep, queued saturating RMW training and rollback; BP_PHT_BYPASS_EN selects W->R forwarding over a hazard stall
module bp_pht_update_ctrl #(
  parameter int INDEX_WIDTH = 13,
  parameter int CNT_WIDTH   = 2,
  parameter int CNT_INIT    = 0,
  parameter int QDEPTH_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [INDEX_WIDTH-1:0] upd_index,
  input  logic                   upd_taken,
  input  logic                   rb_valid,
  input  logic [INDEX_WIDTH-1:0] rb_index,
  input  logic [CNT_WIDTH-1:0]   rb_cnt,
  output logic                   tbl_re,
  output logic [INDEX_WIDTH-1:0] tbl_raddr,
  input  logic [CNT_WIDTH-1:0]   tbl_rdata,
  output logic                   tbl_we,
  output logic [INDEX_WIDTH-1:0] tbl_waddr,
  output logic [CNT_WIDTH-1:0]   tbl_wdata,
  output logic                   init_done,
  output logic [QDEPTH_LOG2:0]   q_count
);

  localparam int QDEPTH = 1 << QDEPTH_LOG2;
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]   INIT_VAL = CNT_WIDTH'(CNT_INIT);
  localparam logic [QDEPTH_LOG2:0]   Q_FULL   = (QDEPTH_LOG2+1)'(QDEPTH);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [INDEX_WIDTH-1:0]   q_idx_q [QDEPTH];
  logic [INDEX_WIDTH-1:0]   q_idx_d [QDEPTH];
  logic [QDEPTH-1:0]        q_tkn_q, q_tkn_d;
  logic [QDEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [QDEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [QDEPTH_LOG2:0]     cnt_q, cnt_d;
  logic                     w_valid_q, w_valid_d;
  logic [INDEX_WIDTH-1:0]   w_idx_q, w_idx_d;
  logic                     w_tkn_q, w_tkn_d;
`ifdef BP_PHT_BYPASS_EN
  logic                     w_byp_q, w_byp_d;
  logic [CNT_WIDTH-1:0]     w_byp_data_q, w_byp_data_d;
`endif

  logic                     run;
  logic                     q_empty;
  logic                     q_full;
  logic [INDEX_WIDTH-1:0]   head_idx;
  logic                     head_tkn;
  logic                     hazard;
  logic                     hold;
  logic                     pop;
  logic                     push;
  logic [CNT_WIDTH-1:0]     w_cur;
  logic [CNT_WIDTH-1:0]     w_new;

  // Queue head, hazard detection, pop/accept decisions and the W-stage counter update
  always_comb begin
    run      = rst_n && (state_q == ST_RUN);
    q_empty  = (cnt_q == '0);
    q_full   = (cnt_q == Q_FULL);
    head_idx = q_idx_q[rd_ptr_q];
    head_tkn = q_tkn_q[rd_ptr_q];
    hazard   = w_valid_q && (head_idx == w_idx_q);
`ifdef BP_PHT_BYPASS_EN
    hold     = 1'b0;
    w_cur    = w_byp_q ? w_byp_data_q : tbl_rdata;
`else
    hold     = hazard;
    w_cur    = tbl_rdata;
`endif
    pop      = run && !rb_valid && !q_empty && !hold;
    // A full queue still accepts when the head leaves in the same cycle.
    upd_ready = run && !rb_valid && (!q_full || pop);
    push     = upd_valid && upd_ready;
    if (w_tkn_q) begin
      w_new = (w_cur == CNT_MAX) ? w_cur : w_cur + CNT_WIDTH'(1);
    end else begin
      w_new = (w_cur == '0) ? w_cur : w_cur - CNT_WIDTH'(1);
    end
  end

  // Table port drive: init sweep, else rollback, else W write and R read
  always_comb begin
    tbl_re    = 1'b0;
    tbl_raddr = '0;
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;
    init_done = rst_n && (state_q == ST_RUN);
    q_count   = rst_n ? cnt_q : '0;
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        tbl_we    = 1'b1;
        tbl_waddr = ptr_q;
        tbl_wdata = INIT_VAL;
      end else if (rb_valid) begin
        tbl_we    = 1'b1;
        tbl_waddr = rb_index;
        tbl_wdata = rb_cnt;
      end else begin
        if (w_valid_q) begin
          tbl_we    = 1'b1;
          tbl_waddr = w_idx_q;
          tbl_wdata = w_new;
        end
        if (pop) begin
          tbl_re    = 1'b1;
          tbl_raddr = head_idx;
        end
      end
    end
  end

  // Next-state: sweep pointer, FIFO pointers/occupancy and the W register
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    q_idx_d   = q_idx_q;
    q_tkn_d   = q_tkn_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    w_valid_d = pop;
    w_idx_d   = pop ? head_idx : w_idx_q;
    w_tkn_d   = pop ? head_tkn : w_tkn_q;
`ifdef BP_PHT_BYPASS_EN
    w_byp_d      = pop && hazard;
    w_byp_data_d = w_new;
`endif
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + INDEX_WIDTH'(1);
        if (ptr_q == '1) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (rb_valid) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
        end else begin
          if (push) begin
            q_idx_d[wr_ptr_q] = upd_index;
            q_tkn_d[wr_ptr_q] = upd_taken;
            wr_ptr_d          = wr_ptr_q + QDEPTH_LOG2'(1);
          end
          if (pop) begin
            rd_ptr_d = rd_ptr_q + QDEPTH_LOG2'(1);
          end
          if (push && !pop) begin
            cnt_d = cnt_q + (QDEPTH_LOG2+1)'(1);
          end else if (pop && !push) begin
            cnt_d = cnt_q - (QDEPTH_LOG2+1)'(1);
          end
        end
      end
    endcase
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      ptr_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      w_valid_q <= 1'b0;
      w_idx_q   <= '0;
      w_tkn_q   <= 1'b0;
`ifdef BP_PHT_BYPASS_EN
      w_byp_q      <= 1'b0;
      w_byp_data_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      w_valid_q <= w_valid_d;
      w_idx_q   <= w_idx_d;
      w_tkn_q   <= w_tkn_d;
`ifdef BP_PHT_BYPASS_EN
      w_byp_q      <= w_byp_d;
      w_byp_data_q <= w_byp_data_d;
`endif
    end
  end

  // Queue payload storage; occupancy alone decides validity, so no reset needed
  always_ff @(posedge clk) begin
    q_idx_q <= q_idx_d;
    q_tkn_q <= q_tkn_d;
  end

endmodule

// File: tb/tb_bp_pht_update_ctrl.sv
// tb/tb_bp_pht_update_ctrl.sv - scoreboard bench for bp_pht_update_ctrl
module tb_bp_pht_update_ctrl;

  localparam int IW = 4;
  localparam int CW = 2;
  localparam int QL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [IW-1:0] upd_index = '0;
  logic          upd_taken = 1'b0;
  logic          rb_valid = 1'b0;
  logic [IW-1:0] rb_index = '0;
  logic [CW-1:0] rb_cnt = '0;
  logic          tbl_re;
  logic [IW-1:0] tbl_raddr;
  logic [CW-1:0] tbl_rdata = '0;
  logic          tbl_we;
  logic [IW-1:0] tbl_waddr;
  logic [CW-1:0] tbl_wdata;
  logic          init_done;
  logic [QL:0]   q_count;

  bp_pht_update_ctrl #(
    .INDEX_WIDTH(IW),
    .CNT_WIDTH(CW),
    .CNT_INIT(1),
    .QDEPTH_LOG2(QL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_index(upd_index),
    .upd_taken(upd_taken),
    .rb_valid(rb_valid),
    .rb_index(rb_index),
    .rb_cnt(rb_cnt),
    .tbl_re(tbl_re),
    .tbl_raddr(tbl_raddr),
    .tbl_rdata(tbl_rdata),
    .tbl_we(tbl_we),
    .tbl_waddr(tbl_waddr),
    .tbl_wdata(tbl_wdata),
    .init_done(init_done),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] a;
    logic [CW-1:0] d;
  } wr_t;

  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  wr_t           exp_q[$];
  int            wr_cyc[$];
  logic [CW-1:0] ref_c [16];
  logic [CW-1:0] committed [16];
  logic [CW-1:0] mem [16];
  wr_t           mon_e;

  // Synchronous-read table with read-old-data behaviour on a same-edge write
  always @(posedge clk) begin
    if (tbl_re) tbl_rdata <= mem[tbl_raddr];
    if (tbl_we) mem[tbl_waddr] <= tbl_wdata;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every table write in RUN/INIT is matched in order against the scoreboard
  always @(negedge clk) begin
    if (rst_n && tbl_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 32'(tbl_we), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(tbl_waddr), 32'(mon_e.a));
        check("wr_data", 32'(tbl_wdata), 32'(mon_e.d));
        committed[mon_e.a] = mon_e.d;
        wr_cyc.push_back(cyc);
      end
    end
  end

  task automatic accept(input logic [IW-1:0] idx, input logic tk);
    logic [CW-1:0] v;
    wr_t e;
    v = ref_c[idx];
    if (tk) v = (v == 2'd3) ? v : v + 2'd1;
    else    v = (v == 2'd0) ? v : v - 2'd1;
    ref_c[idx] = v;
    e.a = idx;
    e.d = v;
    exp_q.push_back(e);
  endtask

  task automatic push_upd(input logic [IW-1:0] idx, input logic tk);
    bit done;
    done = 1'b0;
    upd_valid = 1'b1;
    upd_index = idx;
    upd_taken = tk;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (upd_ready) begin
        accept(idx, tk);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("upd_accept_timeout", 32'(done), 32'(1));
  endtask

  task automatic do_rollback(input logic [IW-1:0] idx, input logic [CW-1:0] c);
    wr_t e;
    rb_valid = 1'b1;
    rb_index = idx;
    rb_cnt   = c;
    exp_q.delete();
    ref_c = committed;
    ref_c[idx] = c;
    e.a = idx;
    e.d = c;
    exp_q.push_back(e);
    @(negedge clk);
    check("rb_no_re", 32'(tbl_re), 32'(0));
    check("rb_ready", 32'(upd_ready), 32'(0));
    check("rb_we", 32'(tbl_we), 32'(1));
    @(posedge clk); #1;
    rb_valid  = 1'b0;
    upd_valid = 1'b0;
    @(negedge clk);
    check("rb_qcount", 32'(q_count), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || q_count != 0) && i < 60) begin
      @(posedge clk); #1;
      i++;
    end
    check("drain_left", 32'(exp_q.size()), 32'(0));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic reset_outputs_zero(input string tag);
    @(negedge clk);
    check({tag, "_we"}, 32'(tbl_we), 32'(0));
    check({tag, "_re"}, 32'(tbl_re), 32'(0));
    check({tag, "_done"}, 32'(init_done), 32'(0));
    check({tag, "_ready"}, 32'(upd_ready), 32'(0));
    check({tag, "_qc"}, 32'(q_count), 32'(0));
  endtask

  task automatic start_init();
    wr_t e;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      e.a = IW'(i);
      e.d = 2'd1;
      exp_q.push_back(e);
      ref_c[i] = 2'd1;
      committed[i] = 2'd1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("init_busy_done", 32'(init_done), 32'(0));
      check("init_busy_ready", 32'(upd_ready), 32'(0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("init_done", 32'(init_done), 32'(1));
    check("init_ready", 32'(upd_ready), 32'(1));
    check("init_writes", 32'(exp_q.size()), 32'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    bit stop;
    bit reached;
    bit saw_block;
    int nfull;

    repeat (3) @(posedge clk);
    #1;
    reset_outputs_zero("reset");
    @(posedge clk); #1;
    start_init();

    // Training latency: accept in N, read in N+1, write in N+2
    push_upd(4'd6, 1'b1);
    upd_valid = 1'b0;
    @(negedge clk);
    check("lat_re", 32'(tbl_re), 32'(1));
    check("lat_raddr", 32'(tbl_raddr), 32'(6));
    @(negedge clk);
    check("lat_we", 32'(tbl_we), 32'(1));
    @(posedge clk); #1;
    wait_drain();

    // Saturation up then down from 0
    do_rollback(4'd3, 2'd0);
    repeat (5) push_upd(4'd3, 1'b1);
    push_upd(4'd3, 1'b0);
    upd_valid = 1'b0;
    wait_drain();
    check("sat_hi_mem", 32'(mem[3]), 32'(2));
    do_rollback(4'd4, 2'd0);
    repeat (4) push_upd(4'd4, 1'b0);
    upd_valid = 1'b0;
    wait_drain();
    check("sat_lo_mem", 32'(mem[4]), 32'(0));

    // Same-index streak timing
    do_rollback(4'd5, 2'd0);
    wr_cyc.delete();
    repeat (3) push_upd(4'd5, 1'b1);
    upd_valid = 1'b0;
    wait_drain();
`ifdef BP_PHT_BYPASS_EN
    gap = 1;
`else
    gap = 2;
`endif
    check("streak_nwr", 32'(wr_cyc.size()), 32'(3));
    check("streak_gap1", 32'(wr_cyc[1] - wr_cyc[0]), 32'(gap));
    check("streak_gap2", 32'(wr_cyc[2] - wr_cyc[1]), 32'(gap));
    check("streak_mem", 32'(mem[5]), 32'(3));

`ifndef BP_PHT_BYPASS_EN
    // Full queue under back-to-back same-index hazards
    upd_valid = 1'b1;
    upd_index = 4'd2;
    upd_taken = 1'b1;
    reached = 1'b0;
    saw_block = 1'b0;
    nfull = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (reached) check("full_occ", 32'(q_count), 32'(4));
      if (q_count == 3'd4) begin
        reached = 1'b1;
        nfull++;
        if (!upd_ready) saw_block = 1'b1;
      end
      if (upd_ready) accept(4'd2, 1'b1);
      @(posedge clk); #1;
      if (nfull >= 10) break;
    end
    upd_valid = 1'b0;
    check("full_reached", 32'(reached), 32'(1));
    check("full_blocked", 32'(saw_block), 32'(1));
    wait_drain();
`endif

    // Rollback preempts a loaded queue and an in-flight RMW
    upd_valid = 1'b1;
    upd_index = 4'd9;
    upd_taken = 1'b1;
    stop = 1'b0;
    for (int i = 0; i < 12 && !stop; i++) begin
      @(negedge clk);
      if (upd_ready) accept(4'd9, 1'b1);
      if (q_count == 3'd4 && tbl_re) stop = 1'b1;
      @(posedge clk); #1;
    end
    do_rollback(4'd7, 2'd2);
    wait_drain();
    check("rb_mem", 32'(mem[7]), 32'(2));

    // Reset in the middle of training
    repeat (3) push_upd(4'd10, 1'b1);
    rst_n = 1'b0;
    upd_valid = 1'b0;
    exp_q.delete();
    reset_outputs_zero("midrst");
    @(posedge clk); #1;
    reset_outputs_zero("midrst2");
    @(posedge clk); #1;
    start_init();
    wait_drain();
    check("midrst_mem", 32'(mem[10]), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_pht_update_ctrl.md
# bp_pht_update_ctrl

Sequencer for one pattern-history table (PHT) of the branch predictor. It owns the table's single write port and single read port. After reset it sweeps every entry to a known counter value. It then serialises queued speculative taken/not-taken training requests into pipelined read-modify-write saturating updates. A pipeline-flush rollback preempts everything: it restores one entry and discards all queued and in-flight training. One instance sits beside each GHP/LHP table.

## Interface
- `INDEX_WIDTH`, 13: table index width; the table has 2^INDEX_WIDTH entries.
- `CNT_WIDTH`, 2: jump-status counter width.
- `CNT_INIT`, 0: value written to every entry by the init sweep.
- `QDEPTH_LOG2`, 2: training queue depth is 2^QDEPTH_LOG2.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `upd_valid`  in  1  training request.
- `upd_ready`  out  1  request accepted when `upd_valid && upd_ready`.
- `upd_index`  in  INDEX_WIDTH  entry to train.
- `upd_taken`  in  1  1 = increment, 0 = decrement.
- `rb_valid`  in  1  rollback request (single-cycle pulse).
- `rb_index`  in  INDEX_WIDTH  entry to restore.
- `rb_cnt`  in  CNT_WIDTH  value to restore.
- `tbl_re`  out  1  table read enable.
- `tbl_raddr`  out  INDEX_WIDTH  read address.
- `tbl_rdata`  in  CNT_WIDTH  read data, valid the cycle after `tbl_re`.
- `tbl_we`  out  1  table write enable.
- `tbl_waddr`  out  INDEX_WIDTH  write address.
- `tbl_wdata`  out  CNT_WIDTH  write data.
- `init_done`  out  1  sweep complete.
- `q_count`  out  QDEPTH_LOG2+1  current queue occupancy.

## Operation
- States: INIT and RUN.
- **Reset** (any state, any cycle): go to INIT, sweep pointer = 0, queue emptied, pipeline squashed. All outputs are 0 during reset.
- **INIT:**
  - Each cycle drives `tbl_we`=1, `tbl_waddr`=pointer, `tbl_wdata`=CNT_INIT, then increments the pointer.
  - After writing entry 2^INDEX_WIDTH-1, go to RUN and set `init_done`=1.
  - `upd_ready`=0 throughout INIT. `rb_valid` is ignored in INIT.
- **Queue:** FIFO of {index, taken}.
  - `upd_ready` = RUN && !full && !rb_valid.
  - Push and pop in the same cycle is allowed when full; occupancy is unchanged.
- **Read stage (R):** when the queue is non-empty and R is not held, pop the head, drive `tbl_re`=1 and `tbl_raddr`=index, and latch {index, taken} into the W register.
- **Write stage (W):** the cycle after R, compute the new counter from `tbl_rdata`, then drive `tbl_we`=1, `tbl_waddr`, `tbl_wdata`.
  - taken: min(c+1, 2^CNT_WIDTH-1).
  - not taken: max(c-1, 0).
  - Arithmetic is CNT_WIDTH wide and never wraps.
- **Rollback** (RUN, `rb_valid`=1) has highest priority in that cycle:
  - Drive `tbl_we`=1, `tbl_waddr`=rb_index, `tbl_wdata`=rb_cnt.
  - The pending W write is dropped.
  - The R stage and the queue are cleared, so `q_count`=0 next cycle.
  - No `tbl_re` is issued that cycle.
  - An upd offered in the same cycle is not accepted.
- Read-after-write hazard on the same index is resolved by the configuration below.

## Timing
- Init sweep takes exactly 2^INDEX_WIDTH cycles after the reset release cycle. `init_done` rises in the cycle after the last init write.
- Training latency: request accepted in cycle N → `tbl_re` in N+1 at the earliest (queue registered) → `tbl_we` in N+2.
- Throughput is one update per cycle when there are no hazards.
- `q_count` updates the cycle after a push or pop.
- Rollback takes effect in the same cycle `rb_valid` is sampled. The queue accepts new requests from the next cycle.

## Configuration
- `BP_PHT_BYPASS_EN` defined:
  - When R reads index X while W writes index X in the same cycle, the next W uses W's `tbl_wdata` in place of `tbl_rdata`.
  - R never stalls; back-to-back same-index updates sustain one per cycle.
- Undefined:
  - R is held (no pop, `tbl_re`=0) for one cycle whenever the head index equals the W index being written.
  - The pair then completes with a one-cycle bubble.
- Final table contents are identical in both builds.

## Test plan
- **Init sweep.** INDEX_WIDTH=4, CNT_INIT=1; release reset → 16 writes of 1 to addresses 0..15 on consecutive cycles; `init_done`=1 on cycle 17; `upd_ready`=0 until then.
- **Saturation.** Entry 3 = 0; push five taken updates to index 3 → written values 1, 2, 3, 3, 3. Then one not-taken update → 2. Four not-taken from 0 → writes stay 0.
- **Same-index streak.** Three back-to-back taken updates to index 5 from 0 → final 3. With the macro: three writes on consecutive cycles. Without: a bubble between each pair.
- **Rollback preemption.** Queue holds 4 updates with one RMW in W; pulse `rb_valid`, index 7, cnt 2 → only write that cycle is 7←2; no further writes; `q_count`=0 next cycle.
- **Full queue.** QDEPTH_LOG2=2, table read stalled by back-to-back same-index hazards, macro off → `upd_ready`=0 at `q_count`=4; simultaneous push+pop keeps 4.
- **Reset mid-operation.** Assert `rst_n`=0 during RUN with 3 queued updates → queue empty, sweep restarts at address 0, none of the queued writes appear.
